// File: rtl/result_streamer_pkg.sv
// Shared types and constants for the result readout streamer.
// Holds the FSM state encoding, the word-FIFO depth and a lane-counter width helper.
package result_streamer_pkg;

  typedef enum logic [1:0] {
    RS_IDLE   = 2'd0,
    RS_RUN    = 2'd1,
    RS_FINISH = 2'd2
  } result_streamer_state_t;

  localparam int RS_FIFO_DEPTH = 2;

  // Lane counter needs at least one bit even for a single-lane word.
  function automatic int lane_width(input int lanes);
    return (lanes > 1) ? $clog2(lanes) : 1;
  endfunction

endpackage

// File: rtl/result_streamer_if.sv
// Valid/ready output stream of the result streamer (host-facing).
// The master drives data/valid/last; the slave returns ready.
interface result_streamer_if
  import result_streamer_pkg::*;
#(
  parameter int DATA_WIDTH = 32
);

  logic [DATA_WIDTH-1:0] m_tdata;
  logic                  m_tvalid;
  logic                  m_tready;
  logic                  m_tlast;

  modport master (
    output m_tdata,
    output m_tvalid,
    output m_tlast,
    input  m_tready
  );

  modport slave (
    input  m_tdata,
    input  m_tvalid,
    input  m_tlast,
    output m_tready
  );

endinterface

// File: rtl/result_streamer_word_fifo.sv
// Two-entry word FIFO buffering BRAM read data ahead of the lane serialiser.
// Push on a full FIFO is accepted only together with a pop; count feeds the read-credit logic.
module word_fifo
  import result_streamer_pkg::*;
#(
  parameter int WIDTH = 128
) (
  input  logic                                   clk,
  input  logic                                   rstn,
  input  logic                                   push,
  input  logic [WIDTH-1:0]                       din,
  input  logic                                   pop,
  output logic [WIDTH-1:0]                       dout,
  output logic [$clog2(RS_FIFO_DEPTH+1)-1:0]     count,
  output logic                                   empty
);

  localparam int PTR_W = $clog2(RS_FIFO_DEPTH);
  localparam int CNT_W = $clog2(RS_FIFO_DEPTH + 1);

  logic [WIDTH-1:0] mem_q [RS_FIFO_DEPTH];
  logic [WIDTH-1:0] mem_d [RS_FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign full  = (count_q == CNT_W'(RS_FIFO_DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign dout  = mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    do_pop   = pop && !empty;
    // A full FIFO still takes a push when the head leaves in the same cycle.
    do_push  = push && (!full || do_pop);
    if (do_push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < RS_FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/result_streamer.sv
// Reads PE_COUNT-lane result words from the BRAM read port and serialises them,
// lane 0 first, onto a DATA_WIDTH-bit valid/ready stream with tlast on the final beat.
module result_streamer
  import result_streamer_pkg::*;
#(
  parameter int PE_COUNT   = 4,
  parameter int DATA_WIDTH = 32,
  parameter int BRAM_DEPTH = 1024,
  parameter int ADDR_WIDTH = $clog2(BRAM_DEPTH)
) (
  input  logic                                 clk,
  input  logic                                 rstn,
  input  logic                                 start,
  input  logic [ADDR_WIDTH-1:0]                base_addr,
  input  logic [ADDR_WIDTH:0]                  word_count,
  output logic                                 busy,
  output logic                                 done,
  output logic                                 bram_rd_en,
  output logic [ADDR_WIDTH-1:0]                bram_rd_addr,
  input  logic [PE_COUNT-1:0][DATA_WIDTH-1:0]  bram_rd_dout,
  result_streamer_if.master                    m_axis
);

  localparam int LANE_W = lane_width(PE_COUNT);
  localparam int WORD_W = PE_COUNT * DATA_WIDTH;
  localparam int CNT_W  = $clog2(RS_FIFO_DEPTH + 1);
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(PE_COUNT - 1);
  localparam logic [CNT_W:0]    CREDIT    = (CNT_W + 1)'(RS_FIFO_DEPTH);

  result_streamer_state_t state_q, state_d;
  logic [ADDR_WIDTH-1:0]  base_q, base_d;
  logic [ADDR_WIDTH:0]    wc_q, wc_d;
  logic [ADDR_WIDTH:0]    issue_q, issue_d;
  logic [ADDR_WIDTH:0]    emit_q, emit_d;
  logic [LANE_W-1:0]      lane_q, lane_d;
  logic                   inflight_q, inflight_d;

  logic [PE_COUNT-1:0][DATA_WIDTH-1:0] head_word;
  logic [CNT_W-1:0]       fifo_count;
  logic                   fifo_empty;
  logic                   lane_last;
  logic                   last_word;
  logic                   tvalid;
  logic                   tlast;
  logic [DATA_WIDTH-1:0]  tdata;
  logic                   handshake;
  logic                   pop;
  logic                   rd_en;
  logic [CNT_W:0]         credit_used;

  word_fifo #(
    .WIDTH (WORD_W)
  ) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (inflight_q),
    .din   (bram_rd_dout),
    .pop   (pop),
    .dout  (head_word),
    .count (fifo_count),
    .empty (fifo_empty)
  );

  // Serialiser view of the FIFO head word.
  always_comb begin
    lane_last = (lane_q == LAST_LANE);
    last_word = (emit_q == (wc_q - (ADDR_WIDTH + 1)'(1)));
    tvalid    = (state_q == RS_RUN) && !fifo_empty;
    tlast     = tvalid && lane_last && last_word;
    tdata     = tvalid ? head_word[lane_q] : '0;
    handshake = tvalid && m_axis.m_tready;
    pop       = handshake && lane_last;
  end

  // Words in the FIFO plus the one in flight, less the word leaving now, must stay under depth.
  always_comb begin
    credit_used = {1'b0, fifo_count} + (CNT_W + 1)'(inflight_q);
    rd_en       = (state_q == RS_RUN) && (issue_q != wc_q) &&
                  (credit_used < (CREDIT + (CNT_W + 1)'(pop)));
  end

  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    wc_d       = wc_q;
    issue_d    = issue_q;
    emit_d     = emit_q;
    lane_d     = lane_q;
    inflight_d = rd_en;
    busy       = 1'b0;
    done       = 1'b0;
    unique case (state_q)
      RS_IDLE: begin
        if (start) begin
          base_d  = base_addr;
          wc_d    = word_count;
          issue_d = '0;
          emit_d  = '0;
          lane_d  = '0;
          state_d = (word_count == '0) ? RS_FINISH : RS_RUN;
        end
      end
      RS_RUN: begin
        busy = 1'b1;
        if (rd_en) begin
          issue_d = issue_q + 1'b1;
        end
        if (handshake) begin
          lane_d = lane_last ? '0 : lane_q + 1'b1;
          if (lane_last) begin
            emit_d = emit_q + 1'b1;
          end
          if (tlast) begin
            state_d = RS_FINISH;
          end
        end
      end
      RS_FINISH: begin
        done    = 1'b1;
        state_d = RS_IDLE;
      end
      default: begin
        state_d = RS_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= RS_IDLE;
      base_q     <= '0;
      wc_q       <= '0;
      issue_q    <= '0;
      emit_q     <= '0;
      lane_q     <= '0;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      wc_q       <= wc_d;
      issue_q    <= issue_d;
      emit_q     <= emit_d;
      lane_q     <= lane_d;
      inflight_q <= inflight_d;
    end
  end

  assign bram_rd_en      = rd_en;
  assign bram_rd_addr    = rd_en ? base_q + issue_q[ADDR_WIDTH-1:0] : '0;
  assign m_axis.m_tdata  = tdata;
  assign m_axis.m_tvalid = tvalid;
  assign m_axis.m_tlast  = tlast;

endmodule

// File: tb/tb_result_streamer.sv
// Directed and randomized readouts of result_streamer against a queue-based beat model.
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
module tb_result_streamer;
  import result_streamer_pkg::*;

  localparam int PE    = 4;
  localparam int DW    = 32;
  localparam int DEPTH = 1024;
  localparam int AW    = 10;

  logic                   clk = 1'b0;
  logic                   rstn;
  logic                   start;
  logic [AW-1:0]          base_addr;
  logic [AW:0]            word_count;
  logic                   busy;
  logic                   done;
  logic                   bram_rd_en;
  logic [AW-1:0]          bram_rd_addr;
  logic [PE-1:0][DW-1:0]  bram_rd_dout;

  result_streamer_if #(.DATA_WIDTH(DW)) axis ();

  result_streamer #(
    .PE_COUNT   (PE),
    .DATA_WIDTH (DW),
    .BRAM_DEPTH (DEPTH),
    .ADDR_WIDTH (AW)
  ) dut (
    .clk          (clk),
    .rstn         (rstn),
    .start        (start),
    .base_addr    (base_addr),
    .word_count   (word_count),
    .busy         (busy),
    .done         (done),
    .bram_rd_en   (bram_rd_en),
    .bram_rd_addr (bram_rd_addr),
    .bram_rd_dout (bram_rd_dout),
    .m_axis       (axis.master)
  );

  always #5 clk = ~clk;

  // Result BRAM: word k lane j holds {k, j}; one-cycle read latency.
  logic [PE-1:0][DW-1:0] mem_model [DEPTH];
  always @(posedge clk) begin
    if (bram_rd_en) bram_rd_dout <= mem_model[bram_rd_addr];
  end

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  beat_t          exp_q[$];
  logic [AW-1:0]  r_addrs[$];
  int             r_first_beat, r_done_cyc, r_beats, r_reads;
  logic [DW-1:0]  r_last_data;
  int             n_assert = 0;
  int             n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run_readout(input logic [AW-1:0] b, input int cnt, input int low_pct, input bit poke);
    int            cyc;
    int            limit;
    bit            done_seen;
    bit            stall_prev;
    logic [DW-1:0] prev_data;
    logic          prev_last;
    beat_t         bt;
    exp_q.delete();
    r_addrs.delete();
    for (int i = 0; i < cnt; i++) begin
      for (int j = 0; j < PE; j++) begin
        bt.data = mem_model[(int'(b) + i) % DEPTH][j];
        bt.last = (i == cnt - 1) && (j == PE - 1);
        exp_q.push_back(bt);
      end
    end
    r_first_beat = -1; r_done_cyc = -1; r_beats = 0; r_reads = 0; r_last_data = '0;
    done_seen = 0; stall_prev = 0; prev_data = '0; prev_last = 0;
    limit = cnt * PE * 20 + 50;
    @(negedge clk);
    start = 1'b1; base_addr = b; word_count = (AW + 1)'(cnt); axis.m_tready = 1'b1;
    @(negedge clk);
    cyc = 1;
    while (!done_seen && cyc < limit) begin
      if (poke && cyc == 5) begin
        start = 1'b1; base_addr = AW'($urandom); word_count = (AW + 1)'($urandom_range(1, 50));
      end else begin
        start = 1'b0;
      end
      axis.m_tready = ($urandom_range(0, 99) >= low_pct);
      #1;
      if (stall_prev) begin
        check("stall_valid", axis.m_tvalid, 1);
        check("stall_data", axis.m_tdata, prev_data);
        check("stall_last", axis.m_tlast, prev_last);
      end
      if (bram_rd_en) begin
        check("rd_addr", bram_rd_addr, (int'(b) + r_reads) % DEPTH);
        check("rd_excess", r_reads < cnt, 1);
        r_addrs.push_back(bram_rd_addr);
        r_reads++;
      end
      if (axis.m_tvalid && axis.m_tready) begin
        if (r_beats == 0) r_first_beat = cyc;
        if (exp_q.size() == 0) begin
          check("beat_excess", 1, 0);
        end else begin
          bt = exp_q.pop_front();
          check("beat_data", axis.m_tdata, bt.data);
          check("beat_last", axis.m_tlast, bt.last);
        end
        r_last_data = axis.m_tdata;
        r_beats++;
      end
      check("fifo_ovf", dut.u_fifo.push && (dut.u_fifo.count == 2) && !dut.u_fifo.pop, 0);
      if (done) begin
        check("done_busy", busy, 0);
        done_seen = 1;
        r_done_cyc = cyc;
      end else begin
        check("busy_run", busy, 1);
      end
      stall_prev = axis.m_tvalid && !axis.m_tready;
      prev_data  = axis.m_tdata;
      prev_last  = axis.m_tlast;
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    #1;
    check("done_seen", done_seen, 1);
    check("done_pulse", done, 0);
    check("idle_busy", busy, 0);
    check("beat_count", r_beats, cnt * PE);
    check("read_count", r_reads, cnt);
    check("exp_left", exp_q.size(), 0);
    $display("readout base=%0d words=%0d beats=%0d reads=%0d first_beat=%0d done_cyc=%0d",
             b, cnt, r_beats, r_reads, r_first_beat, r_done_cyc);
  endtask

  initial begin
    int n;
    for (int k = 0; k < DEPTH; k++) begin
      for (int j = 0; j < PE; j++) begin
        mem_model[k][j] = {16'(k), 16'(j)};
      end
    end
    bram_rd_dout = '0;
    rstn = 1'b0; start = 1'b0; base_addr = '0; word_count = '0; axis.m_tready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_rd_en", bram_rd_en, 0);
    check("rst_rd_addr", bram_rd_addr, 0);
    check("rst_tdata", axis.m_tdata, 0);
    check("rst_tvalid", axis.m_tvalid, 0);
    check("rst_tlast", axis.m_tlast, 0);
    @(negedge clk);
    rstn = 1'b1;

    // Basic readout: 3 words from 5, back-to-back beats.
    run_readout(10'd5, 3, 0, 0);
    check("basic_first", r_first_beat, 3);
    check("basic_done", r_done_cyc, 15);

    // Zero-length readout.
    run_readout(AW'($urandom), 0, 0, 0);
    check("zero_done", r_done_cyc, 1);
    check("zero_reads", r_reads, 0);
    check("zero_beats", r_beats, 0);

    // Address wrap.
    run_readout(10'd1022, 4, 0, 0);
    check("wrap_n", r_addrs.size(), 4);
    if (r_addrs.size() == 4) begin
      check("wrap_a0", r_addrs[0], 1022);
      check("wrap_a1", r_addrs[1], 1023);
      check("wrap_a2", r_addrs[2], 0);
      check("wrap_a3", r_addrs[3], 1);
    end

    // Full-depth readout.
    run_readout(10'd0, DEPTH, 0, 0);
    check("full_last", r_last_data, {16'd1023, 16'd3});
    check("full_done", r_done_cyc, 3 + DEPTH * PE);

    // Random backpressure, 8 words.
    run_readout(AW'($urandom), 8, 30, 0);

    // Randomized readouts, some with a stray start while busy.
    for (int t = 0; t < 4; t++) begin
      n = $urandom_range(1, 20);
      run_readout(AW'($urandom), n, $urandom_range(0, 50), n >= 2);
    end

    // start while busy: timing and addresses unchanged.
    run_readout(10'd200, 5, 0, 1);
    check("poke_done", r_done_cyc, 3 + 5 * PE);

    // Abort mid-readout, then restart.
    @(negedge clk);
    start = 1'b1; base_addr = 10'd100; word_count = 11'd6; axis.m_tready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    #1;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_rd_en", bram_rd_en, 0);
    check("abort_rd_addr", bram_rd_addr, 0);
    check("abort_tdata", axis.m_tdata, 0);
    check("abort_tvalid", axis.m_tvalid, 0);
    check("abort_tlast", axis.m_tlast, 0);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      #1;
      check("abort_no_done", done, 0);
      check("abort_no_beat", axis.m_tvalid, 0);
    end
    run_readout(10'd0, 1, 0, 0);
    check("restart_first", r_first_beat, 3);
    check("restart_last", r_last_data, {16'd0, 16'd3});

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
